// File: rtl/display_scan_driver_pkg.sv
// Shared definitions for the 7-segment scan driver: scan FSM encoding and
// active-low {g,f,e,d,c,b,a} glyphs for hex digits 0-F.
package display_scan_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

endpackage

// File: rtl/display_scan_driver_if.sv
// Data-load and display-output bundle of the scan driver; the driver uses the
// slave view, the data producer / display side uses the master view.
interface display_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   data_in;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     digit_sel;
    logic [6:0]            segments;
    logic                  dp;
    logic                  frame_start;

    modport master (
        output load, data_in, dp_in,
        input  digit_sel, segments, dp, frame_start
    );

    modport slave (
        input  load, data_in, dp_in,
        output digit_sel, segments, dp, frame_start
    );
endinterface

// File: rtl/display_scan_driver_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module hex_to_seg
    import display_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Glyph lookup for 0-9 and A,b,C,d,E,F
    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0:    seg = SEG_HEX_0;
            4'h1:    seg = SEG_HEX_1;
            4'h2:    seg = SEG_HEX_2;
            4'h3:    seg = SEG_HEX_3;
            4'h4:    seg = SEG_HEX_4;
            4'h5:    seg = SEG_HEX_5;
            4'h6:    seg = SEG_HEX_6;
            4'h7:    seg = SEG_HEX_7;
            4'h8:    seg = SEG_HEX_8;
            4'h9:    seg = SEG_HEX_9;
            4'hA:    seg = SEG_HEX_A;
            4'hB:    seg = SEG_HEX_B;
            4'hC:    seg = SEG_HEX_C;
            4'hD:    seg = SEG_HEX_D;
            4'hE:    seg = SEG_HEX_E;
            4'hF:    seg = SEG_HEX_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_scan_driver.sv
// Multiplexed 7-segment scan driver: divider-MSB tick detect, blank/show scan FSM
// and double-buffered digit data, with every display output registered.
module display_scan_driver
    import display_scan_driver_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int DIV_WIDTH    = 18,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                 clk_internal,
    input  logic                 rst_n,
    input  logic [DIV_WIDTH-1:0] clk_divided,
    display_scan_driver_if.slave bus
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = DIV_WIDTH - 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);

    scan_state_e          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     blank_cnt_q, blank_cnt_d;
    logic                 msb_q, msb_d;
    logic [4*DIGITS-1:0]  pending_data_q, pending_data_d;
    logic [4*DIGITS-1:0]  active_data_q, active_data_d;
    logic [DIGITS-1:0]    pending_dp_q, pending_dp_d;
    logic [DIGITS-1:0]    active_dp_q, active_dp_d;
    logic [DIGITS-1:0]    digit_sel_q, digit_sel_d;
    logic [6:0]           segments_q, segments_d;
    logic                 dp_q, dp_d;
    logic                 frame_start_q, frame_start_d;
    logic                 tick;
    logic                 commit;
    logic [3:0]           nibble;
    logic [6:0]           glyph;
    logic                 unused_div_bits;

    // Only the rising edge of the divider MSB counts; the all-ones to zero wrap is a falling edge.
    assign msb_d           = clk_divided[DIV_WIDTH-1];
    assign tick            = msb_d & ~msb_q;
    assign unused_div_bits = ^clk_divided[DIV_WIDTH-2:0];

    // Scan FSM next state plus pending/active buffer update
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        blank_cnt_d = blank_cnt_q;
        commit      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d     = ST_BLANK;
                    idx_d       = {IDX_W{1'b0}};
                    blank_cnt_d = {CNT_W{1'b0}};
                    commit      = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BLANK: begin
                if (blank_cnt_q == BLANK_END) begin
                    state_d     = ST_SHOW;
                    blank_cnt_d = {CNT_W{1'b0}};
                end else begin
                    blank_cnt_d = blank_cnt_q + CNT_W'(1);
                end
            end
            ST_SHOW: begin
                if (tick) begin
                    state_d     = ST_BLANK;
                    blank_cnt_d = {CNT_W{1'b0}};
                    idx_d       = (idx_q == LAST_IDX) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
                    commit      = (idx_q == LAST_IDX);
                end else begin
                    state_d = ST_SHOW;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                idx_d       = {IDX_W{1'b0}};
                blank_cnt_d = {CNT_W{1'b0}};
            end
        endcase

        if (bus.load) begin
            pending_data_d = bus.data_in;
            pending_dp_d   = bus.dp_in;
        end else begin
            pending_data_d = pending_data_q;
            pending_dp_d   = pending_dp_q;
        end

        // Committing from pending_d lets a load in the commit cycle bypass into the active frame.
        if (commit) begin
            active_data_d = pending_data_d;
            active_dp_d   = pending_dp_d;
        end else begin
            active_data_d = active_data_q;
            active_dp_d   = active_dp_q;
        end
    end

    assign nibble = active_data_d[{idx_d, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (glyph)
    );

    // Display outputs are decoded from the next state so they line up with the registered state
    always_comb begin
        digit_sel_d   = {DIGITS{1'b1}};
        segments_d    = SEG_OFF;
        dp_d          = 1'b1;
        frame_start_d = 1'b0;
        if (state_d == ST_SHOW) begin
            digit_sel_d[idx_d] = 1'b0;
            segments_d         = glyph;
            dp_d               = ~active_dp_d[idx_d];
            frame_start_d      = (state_q != ST_SHOW) && (idx_d == {IDX_W{1'b0}});
        end else begin
            frame_start_d = 1'b0;
        end
    end

    // State, buffers and registered outputs
    always_ff @(posedge clk_internal or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= {IDX_W{1'b0}};
            blank_cnt_q    <= {CNT_W{1'b0}};
            msb_q          <= 1'b0;
            pending_data_q <= {(4*DIGITS){1'b0}};
            pending_dp_q   <= {DIGITS{1'b0}};
            active_data_q  <= {(4*DIGITS){1'b0}};
            active_dp_q    <= {DIGITS{1'b0}};
            digit_sel_q    <= {DIGITS{1'b1}};
            segments_q     <= SEG_OFF;
            dp_q           <= 1'b1;
            frame_start_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            blank_cnt_q    <= blank_cnt_d;
            msb_q          <= msb_d;
            pending_data_q <= pending_data_d;
            pending_dp_q   <= pending_dp_d;
            active_data_q  <= active_data_d;
            active_dp_q    <= active_dp_d;
            digit_sel_q    <= digit_sel_d;
            segments_q     <= segments_d;
            dp_q           <= dp_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign bus.digit_sel   = digit_sel_q;
    assign bus.segments    = segments_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = frame_start_q;

endmodule
